// File: rtl/uart_pkg.sv
// Shared constants and the drain-FSM state type for the uart transmit path.
package uart_pkg;

  localparam int BYTE_W               = 8;
  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Byte FIFO storage: wrapping read/write pointers with registered count/full/empty.
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // Guards use the registered flags, so a push is judged on pre-edge fullness.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side byte buffer feeding the uart: valid/ready push side, busy-gated drain FSM.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] uart_din,
  output logic              uart_wr_en,
  input  logic              uart_tx_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output tx_state_e         dbg_state
);

  // Host handshake: a byte transfers on an edge where wr_valid && wr_ready.
  // wr_valid while full drops the byte and latches overflow until reset.

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] din_q, din_d;
  logic              wr_en_q, wr_en_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              overflow_q, overflow_d;
  logic              pop;
  logic [BYTE_W-1:0] rd_data;
  logic              fifo_full, fifo_empty;

  sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (wr_valid & fifo_full);
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !uart_tx_busy) begin
          pop     = 1'b1;
          din_d   = rd_data;
          wr_en_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A uart that never raises busy is assumed to have taken the byte.
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(BUSY_TIMEOUT)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      din_q      <= '0;
      wr_en_q    <= 1'b0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ready   = !fifo_full;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign uart_din   = din_q;
  assign uart_wr_en = wr_en_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-based model with a busy-emulating uart.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]      wr_data = 8'h00;
  logic            wr_valid = 1'b0;
  logic            uart_tx_busy = 1'b0;
  logic            wr_ready;
  logic [7:0]      uart_din;
  logic            uart_wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  tx_state_e       dbg_state;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes held in the FIFO, bytes not yet seen on the uart, and the drain
  // engine described as "edges since the last launch".
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_din;
  logic       m_wr_en;
  logic       m_ovf;
  logic       m_idle;
  logic       m_busy_seen;
  int         m_age;
  int         m_accepts = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_din       = 8'h00;
      m_wr_en     = 1'b0;
      m_ovf       = 1'b0;
      m_idle      = 1'b1;
      m_busy_seen = 1'b0;
      m_age       = 0;
    end else begin
      bit launch;
      bit accept;
      launch = m_idle && (m_q.size() > 0) && !uart_tx_busy;
      accept = wr_valid && (m_q.size() < DEPTH);
      if (wr_valid && m_q.size() == DEPTH) m_ovf = 1'b1;
      m_wr_en = launch;
      if (launch) begin
        m_din       = m_q.pop_front();
        m_idle      = 1'b0;
        m_age       = 0;
        m_busy_seen = 1'b0;
      end else if (!m_idle) begin
        m_age++;
        // Edge 1 after launch drops the strobe; busy is watched from edge 2.
        if (m_age >= 2) begin
          if (!m_busy_seen) begin
            if (uart_tx_busy) m_busy_seen = 1'b1;
            else if (m_age == 1 + BUSY_TIMEOUT) m_idle = 1'b1;
          end else if (!uart_tx_busy) begin
            m_idle = 1'b1;
          end
        end
      end
      if (accept) begin
        m_q.push_back(wr_data);
        exp_q.push_back(wr_data);
        m_accepts++;
      end
    end
  end

  // ---------------- per-cycle monitor / scoreboard ----------------
  bit chk_en = 1'b0;
  int strobes = 0;
  int max_count = 0;
  int wait_busy_cycles = 0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("wr_en",    32'(uart_wr_en), 32'(m_wr_en));
      check("din",      32'(uart_din), 32'(m_din));
      check("count",    32'(count), 32'(m_q.size()));
      check("full",     32'(full), 32'(m_q.size() == DEPTH));
      check("empty",    32'(empty), 32'(m_q.size() == 0));
      check("wr_ready", 32'(wr_ready), 32'(m_q.size() != DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("idle",     32'(dbg_state == IDLE), 32'(m_idle));
      if (int'(count) > max_count) max_count = int'(count);
      if (dbg_state == WAIT_BUSY) wait_busy_cycles++;
      if (uart_wr_en) begin
        strobes++;
        if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size()), 32'd1);
        else check("sb_byte", 32'(uart_din), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- uart busy emulator ----------------
  bit emu_en = 1'b0;
  int emu_left = 0;
  int emu_min = 1;
  int emu_max = 6;
  int emu_drop_pct = 0;

  always @(negedge clk) begin
    if (emu_en && !reset) begin
      if (uart_wr_en) begin
        if ($urandom_range(99) < emu_drop_pct) begin
          uart_tx_busy = 1'b0;
          emu_left = 0;
        end else begin
          uart_tx_busy = 1'b1;
          emu_left = $urandom_range(emu_max, emu_min);
        end
      end else if (emu_left > 0) begin
        emu_left--;
        if (emu_left == 0) uart_tx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int t = 0;
    while (!(empty && dbg_state == IDLE && !uart_tx_busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain_in_time"}, 32'(t < budget), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int s0;
  int a0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_count",    32'(count), 32'd0);
    check("rst_empty",    32'(empty), 32'd1);
    check("rst_full",     32'(full), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_wr_en",    32'(uart_wr_en), 32'd0);
    check("rst_din",      32'(uart_din), 32'd0);
    idle(20);

    // Single byte, uart never raises busy.
    s0 = strobes;
    push_byte(8'hA5);
    check("a5_not_yet", 32'(uart_wr_en), 32'd0);
    @(negedge clk);
    check("a5_strobe",  32'(uart_wr_en), 32'd1);
    check("a5_din",     32'(uart_din), 32'hA5);
    @(negedge clk);
    check("a5_one_cyc", 32'(uart_wr_en), 32'd0);
    check("a5_count",   32'(count), 32'd0);
    wait_drained("a5", 50);
    check("a5_strobes", 32'(strobes - s0), 32'd1);

    // Fill while busy, overflow with the 17th byte, then drain.
    uart_tx_busy = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("fill_full",     32'(full), 32'd1);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_count",    32'(count), 32'd16);
    s0 = strobes;
    uart_tx_busy = 1'b0;
    emu_en = 1'b1;
    emu_drop_pct = 0;
    wait_drained("fill", 400);
    check("fill_strobes", 32'(strobes - s0), 32'd16);

    // Pointer wrap: two rounds of 10 bytes.
    max_count = 0;
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_drained("wrap1", 400);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h20 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_drained("wrap2", 400);
    check("wrap_strobes",   32'(strobes - s0), 32'd20);
    check("wrap_max_count", 32'(max_count <= 10), 32'd1);

    // Timeout path: busy stays low, each byte spends BUSY_TIMEOUT cycles waiting.
    emu_en = 1'b0;
    uart_tx_busy = 1'b0;
    idle(2);
    s0 = strobes;
    wait_busy_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h60 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_drained("tmo", 100);
    check("tmo_strobes",   32'(strobes - s0), 32'd3);
    check("tmo_wait_busy", 32'(wait_busy_cycles), 32'(3 * BUSY_TIMEOUT));

    // Random traffic with random busy lengths and occasional silent uart.
    emu_en = 1'b1;
    emu_drop_pct = 30;
    emu_min = 1;
    emu_max = 5;
    s0 = strobes;
    a0 = m_accepts;
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(99) < 40);
      wr_data  = 8'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_drained("rand", 1000);
    check("rand_strobes", 32'(strobes - s0), 32'(m_accepts - a0));

    // Reset while the uart is busy with bytes still queued.
    emu_drop_pct = 0;
    emu_min = 20;
    emu_max = 30;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    begin
      int t = 0;
      while (dbg_state != WAIT_DONE && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("rst_reach_wait_done", 32'(t < 50), 32'd1);
    end
    check("pre_rst_count", 32'(count), 32'd5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    emu_en = 1'b0;
    emu_left = 0;
    uart_tx_busy = 1'b0;
    #1;
    check("mid_rst_wr_en",    32'(uart_wr_en), 32'd0);
    check("mid_rst_count",    32'(count), 32'd0);
    check("mid_rst_empty",    32'(empty), 32'd1);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_idle",     32'(dbg_state == IDLE), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    s0 = strobes;
    idle(20);
    check("post_rst_no_strobe", 32'(strobes - s0), 32'd0);
    push_byte(8'h3C);
    wait_drained("post_rst", 50);
    check("post_rst_strobes", 32'(strobes - s0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
